// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port synchronous memory between
// instruction fetch and LDR/STR data access, data first with a fairness bound.
// Ports:
//   clk, rst                 clock, async active-high reset
//   fetch_req/pc_addr        fetch request side; fetch_gnt/done/rdata back
//   data_req/addr/we/wdata   data request side; data_gnt/done/rdata back
//   busy                     high while an access is in ISSUE or WAIT
//   mem_en/we/addr/wdata     registered memory bus; mem_rdata returns MEM_LAT later
module mem_bus_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int PC_W       = 8,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int FAIR_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   pc_addr,
    output logic              fetch_gnt,
    output logic              fetch_done,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_we,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_done,
    output logic [DATA_W-1:0] data_rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W  = $clog2(MEM_LAT + 1);
    localparam int FAIR_W = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(MEM_LAT);
    localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [FAIR_W-1:0] fair_q, fair_d;
    logic              sel_data_q, sel_data_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] frd_q, frd_d;
    logic [DATA_W-1:0] drd_q, drd_d;
    logic              arb;
    logic              pick_data;

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        fair_d     = fair_q;
        sel_data_d = sel_data_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        frd_d      = frd_q;
        drd_d      = drd_q;

        arb = ((state_q == IDLE) || (state_q == DONE)) && (fetch_req || data_req);

        // Fetch overtakes data only once data has won FAIR_LIMIT times in a row
        // against a waiting fetch.
        if (data_req && fetch_req)
            pick_data = !((FAIR_LIMIT > 0) && (fair_q == FAIR_MAX));
        else
            pick_data = data_req;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = arb ? ISSUE : IDLE;
            end
            ISSUE: begin
                state_d = WAIT;
                lat_d   = LAT_W'(1);
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = DONE;
                    if (!sel_data_q)
                        frd_d = mem_rdata;
                    else if (!we_q)
                        drd_d = mem_rdata;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
        endcase

        if (arb) begin
            sel_data_d = pick_data;
            if (pick_data) begin
                addr_d  = data_addr;
                wdata_d = data_wdata;
                we_d    = data_we;
                if (!fetch_req)
                    fair_d = '0;
                else if (fair_q != FAIR_MAX)
                    fair_d = fair_q + FAIR_W'(1);
            end else begin
                addr_d = ADDR_W'(pc_addr);
                we_d   = 1'b0;
                fair_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            fair_q     <= '0;
            sel_data_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            frd_q      <= '0;
            drd_q      <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            fair_q     <= fair_d;
            sel_data_q <= sel_data_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            frd_q      <= frd_d;
            drd_q      <= drd_d;
        end
    end

    assign busy        = (state_q == ISSUE) || (state_q == WAIT);
    assign mem_en      = (state_q == ISSUE);
    assign mem_we      = (state_q == ISSUE) && we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign fetch_gnt   = (state_q == ISSUE) && !sel_data_q;
    assign data_gnt    = (state_q == ISSUE) && sel_data_q;
    assign fetch_done  = (state_q == DONE) && !sel_data_q;
    assign data_done   = (state_q == DONE) && sel_data_q;
    assign fetch_rdata = frd_q;
    assign data_rdata  = drd_q;

endmodule
